// File: rtl/pattern_pkg.sv
// Shared definitions for the programmable serial sequence recogniser.
//   - state_e        : controller FSM encoding (IDLE / RUN)
//   - DEFAULT_*      : default sizing for MAX_LEN and CNT_W
//   - len_mask_bit() : length mask, evaluated one bit position at a time
package pattern_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bit idx of the compare mask for a pattern of length len. Only the low
  // len bits of the window take part in the comparison.
  function automatic logic len_mask_bit(input int unsigned idx, input int unsigned len);
    return idx < len;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Sliding-window matcher for pattern_seq_ctrl.
// Holds the bit history, the fill counter and the masked comparator.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   clear        : zero history and fill (new config accepted)
//   shift_en     : a qualified bit is presented on bit_in this cycle
//   bit_in       : incoming serial bit
//   pattern, len : latched pattern and length (1..MAX_LEN)
//   overlap      : 1 = overlapping matches, 0 = restart window after a match
//   hit          : combinational match on the incoming bit
module pattern_window
  import pattern_pkg::*;
#(
  parameter  int MAX_LEN = DEFAULT_MAX_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_inc;
  logic               enough;

  // Window as it will look once the incoming bit is shifted in.
  assign window = {hist[MAX_LEN-2:0], bit_in};

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = len_mask_bit(i, 32'(len));
  end

  // fill counts valid history bits; the incoming bit makes it fill+1.
  assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
  assign enough   = fill_inc >= {1'b0, len};
  assign hit      = shift_en && enough && (((window ^ pattern) & mask) == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= window;
      if (hit && !overlap) fill <= '0;     // next match needs len fresh bits
      else if (enough)     fill <= len;    // saturate at len
      else                 fill <= fill_inc[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Programmable serial sequence recogniser controller.
// Loads a 1..MAX_LEN bit pattern over a valid/ready handshake, then scans
// the qualified serial stream and reports match pulses and a saturating count.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   cfg_valid / cfg_ready        : config handshake (ready only in IDLE)
//   cfg_pattern, cfg_len,
//   cfg_overlap                  : pattern (bit len-1 received first), length, overlap mode
//   cfg_err                      : one-cycle pulse on an illegal cfg_len offer
//   stop                         : abort RUN, back to IDLE
//   A, A_valid                   : serial bit and its qualifier
//   Y                            : registered one-cycle match pulse
//   match_count                  : matches since last accepted config, saturating
//   busy                         : high while in RUN
module pattern_seq_ctrl
  import pattern_pkg::*;
#(
  parameter  int MAX_LEN = DEFAULT_MAX_LEN,
  parameter  int CNT_W   = DEFAULT_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               stop,
  input  logic               A,
  input  logic               A_valid,
  output logic               Y,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  state_e             state, state_nx;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               cfg_legal, accept, reject, shift_en, hit;

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept    = (state == ST_IDLE) && cfg_valid && cfg_legal;
  assign reject    = (state == ST_IDLE) && cfg_valid && !cfg_legal;
  // stop wins over a simultaneous bit: that bit is dropped entirely.
  assign shift_en  = (state == ST_RUN) && A_valid && !stop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (stop)   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: cfg_ready = 1'b1;
      ST_RUN:  busy      = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Config latch, match pulse, cfg_err pulse and saturating counter.
  // NOTE: the config registers are reset along with the control state so the
  // comparator never sees X, even though RUN always follows a fresh load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      Y           <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      Y       <= hit;
      cfg_err <= reject;
      if (accept) begin
        pat_q       <= cfg_pattern;
        len_q       <= cfg_len;
        ovl_q       <= cfg_overlap;
        match_count <= '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  pattern_window #(.MAX_LEN(MAX_LEN)) u_window (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (A),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl: hand-derived vector table,
// hand-written stop/reset sequences, then random traffic against a
// queue-based reference model. A second instance with CNT_W=2 exercises
// counter saturation.
module tb_pattern_seq_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, cfg_valid, cfg_overlap, stop, A, A_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;

  logic        cfg_ready, cfg_err, Y, busy;
  logic [15:0] match_count;
  logic        c2_cfg_ready, c2_cfg_err, c2_Y, c2_busy;
  logic [1:0]  c2_match_count;

  pattern_seq_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err), .stop(stop), .A(A), .A_valid(A_valid), .Y(Y),
    .match_count(match_count), .busy(busy)
  );

  pattern_seq_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(c2_cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(c2_cfg_err), .stop(stop), .A(A), .A_valid(A_valid), .Y(c2_Y),
    .match_count(c2_match_count), .busy(c2_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the received bits since the last config (or
  // since the last match in non-overlap mode) and matches when the newest
  // len bits spell the pattern.
  bit         m_run;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_cnt;
  bit         m_y, m_err;

  function automatic bit model_match();
    if (m_q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_run = 0; m_q.delete(); m_cnt = 0; m_y = 0; m_err = 0;
    end else begin
      m_y = 0; m_err = 0;
      if (!m_run) begin
        if (cfg_valid) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_q.delete(); m_cnt = 0; m_run = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (stop) begin
        m_run = 0;
      end else if (A_valid) begin
        m_q.push_back(A);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (model_match()) begin
          m_y = 1;
          m_cnt++;
          if (!m_ovl) m_q.delete();
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare both DUTs to the model.
  task automatic apply(input logic r, input logic cv, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic stp,
                       input logic a, input logic av);
    rst = r; cfg_valid = cv; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; stop = stp; A = a; A_valid = av;
    model_step();
    @(posedge clk);
    #1;
    check("model.Y",         Y,              m_y);
    check("model.cfg_err",   cfg_err,        m_err);
    check("model.busy",      busy,           m_run);
    check("model.cfg_ready", cfg_ready,      !m_run);
    check("model.count",     match_count,    (m_cnt > 65535) ? 65535 : m_cnt);
    check("model.c2_Y",      c2_Y,           m_y);
    check("model.c2_busy",   c2_busy,        m_run);
    check("model.c2_count",  c2_match_count, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  typedef struct {
    logic       r, cv;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, stp, a, av;
    logic       ey;
    int         ecnt, ecnt2;
    logic       ebusy, eerr;
  } vec_t;

  vec_t tv[$];

  task automatic row(input logic r, input logic cv, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl, input logic stp,
                     input logic a, input logic av, input logic ey,
                     input int ecnt, input int ecnt2, input logic ebusy,
                     input logic eerr);
    vec_t v;
    v.r = r; v.cv = cv; v.pat = pat; v.len = len; v.ovl = ovl; v.stp = stp;
    v.a = a; v.av = av; v.ey = ey; v.ecnt = ecnt; v.ecnt2 = ecnt2;
    v.ebusy = ebusy; v.eerr = eerr;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; stop = 1'b0; A = 1'b0; A_valid = 1'b0;

    //  r  cv pat    len  ovl stp a  av   Y  cnt c2 busy err
    // reset held two cycles with A toggling
    row(0, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    row(0, 0, 8'h00, 4'd0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
    // len=2 pattern 01 overlap; stream 0,1,1,0,1
    row(1, 1, 8'h01, 4'd2, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 2, 2, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 2, 2, 0, 0);
    // len=3 pattern 101 overlap; stream 1,0,1,0,1
    row(1, 1, 8'h05, 4'd3, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 2, 2, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 2, 2, 0, 0);
    // same, non-overlap
    row(1, 1, 8'h05, 4'd3, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 1,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    // illegal lengths 0 and MAX_LEN+1
    row(1, 1, 8'hff, 4'd0, 1, 0, 0, 0,   0, 1, 1, 0, 1);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
    row(1, 1, 8'hff, 4'd9, 1, 0, 0, 0,   0, 1, 1, 0, 1);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
    // len=1 pattern 1, five 1s with gaps; CNT_W=2 instance saturates at 3
    row(1, 1, 8'h01, 4'd1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 0,   0, 1, 1, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 2, 2, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 2, 2, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 3, 3, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 0,   0, 3, 3, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 4, 3, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 0, 0,   0, 4, 3, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 0, 1, 1,   1, 5, 3, 1, 0);
    row(1, 0, 8'h00, 4'd0, 0, 1, 0, 0,   0, 5, 3, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i].r, tv[i].cv, tv[i].pat, tv[i].len, tv[i].ovl,
            tv[i].stp, tv[i].a, tv[i].av);
      check($sformatf("tv%0d.Y", i),         Y,              tv[i].ey);
      check($sformatf("tv%0d.count", i),     match_count,    tv[i].ecnt);
      check($sformatf("tv%0d.c2_count", i),  c2_match_count, tv[i].ecnt2);
      check($sformatf("tv%0d.busy", i),      busy,           tv[i].ebusy);
      check($sformatf("tv%0d.cfg_ready", i), cfg_ready,      !tv[i].ebusy);
      check($sformatf("tv%0d.cfg_err", i),   cfg_err,        tv[i].eerr);
    end

    // stop together with a would-be matching bit: bit dropped, count kept
    apply(1, 1, 8'h01, 4'd2, 1, 0, 0, 0);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 0, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    check("stop.pre_Y", Y, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 0, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 1, 1, 1);
    check("stop.Y",     Y,           0);
    check("stop.busy",  busy,        0);
    check("stop.count", match_count, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    check("stop.idle_Y",     Y,           0);
    check("stop.idle_count", match_count, 1);

    // reset on the same edge as a matching bit: everything back to reset values
    apply(1, 1, 8'h01, 4'd2, 1, 0, 0, 0);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 0, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 0, 1);
    apply(0, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    check("rst.Y",         Y,           0);
    check("rst.count",     match_count, 0);
    check("rst.busy",      busy,        0);
    check("rst.cfg_ready", cfg_ready,   1);
    check("rst.cfg_err",   cfg_err,     0);
    apply(1, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    check("rst.after_Y", Y, 0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic       r, cv, ovl, stp, a, av;
      logic [7:0] pat;
      logic [3:0] len;
      r   = ($urandom_range(0, 199) != 0);
      cv  = ($urandom_range(0, 3) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10))
                                        : 4'($urandom_range(1, 3));
      ovl = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 39) == 0);
      a   = 1'($urandom_range(0, 1));
      av  = ($urandom_range(0, 3) != 0);
      apply(r, cv, pat, len, ovl, stp, a, av);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
Programmable serial sequence recogniser controller. It generalises the fixed "01" detector into a configurable engine: software loads a pattern of 1..MAX_LEN bits plus an overlap mode over a valid/ready config handshake. The block then runs the detector on the qualified serial input and reports single-cycle match pulses and a saturating match count. It sits between the config/register interface and the serial bit stream.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
CNT_W, 16, width of the saturating match counter.
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous reset, active-low.
cfg_valid  in  1  config offer.
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
cfg_pattern  in  MAX_LEN  pattern bits; bit [len-1] is first-received, bit [0] is last-received.
cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = window restarts after each match.
cfg_err  out  1  one-cycle pulse when an illegal cfg_len is offered.
stop  in  1  abort run and return to IDLE.
A  in  1  serial data bit.
A_valid  in  1  A is sampled only when A_valid=1 in RUN.
Y  out  1  one-cycle match pulse.
match_count  out  CNT_W  number of matches since last accepted config; saturates.
busy  out  1  1 while in RUN.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; hist=0; fill=0.
  - Y=0, cfg_err=0, match_count=0, busy=0, cfg_ready=1.
- FSM states: IDLE and RUN. cfg_ready=1 only in IDLE; busy=1 only in RUN.
- IDLE, accept case: cfg_valid=1 with 1<=cfg_len<=MAX_LEN.
  - Latch pattern, len and overlap.
  - Clear hist, fill and match_count.
  - Go to RUN next cycle.
- IDLE, reject case: cfg_valid=1 with cfg_len=0 or cfg_len>MAX_LEN.
  - cfg_err=1 for exactly one cycle (registered).
  - No config latched; stay in IDLE.
- RUN, on each A_valid=1:
  - hist <= {hist[MAX_LEN-2:0], A}.
  - fill <= min(fill+1, len).
- Match condition: (fill+1 >= len) and the low len bits of the new window equal pattern[len-1:0]. Evaluated on the incoming bit.
- Y is registered: it is 1 in the cycle after the matching A_valid cycle, for one cycle only. Back-to-back matches give Y high on consecutive cycles.
- On a match, match_count increments, saturating at 2^CNT_W-1.
- Non-overlap mode: a match forces fill <= 0, so the next match needs len fresh bits. Overlap mode: fill keeps counting.
- A_valid=0 in RUN: no shift and no Y; gaps are transparent.
- stop=1 in RUN: go to IDLE next cycle.
  - stop wins over a simultaneous A_valid; that bit is dropped and cannot produce Y.
  - match_count is retained; Y=0 next cycle.
- stop in IDLE: ignored. cfg_valid in RUN: ignored (cfg_ready=0).
- A_valid is ignored in IDLE.
- Reset mid-RUN: immediate return to reset values at that edge; any pending Y is suppressed.
- len=1: every A_valid bit equal to pattern[0] is a match. Overlap mode is irrelevant.

Decomposition:
- Shared package pattern_pkg:
  - State encodings ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default MAX_LEN and CNT_W constants.
  - A function computing the length mask from len.
- One sub-module: pattern_window. It holds the MAX_LEN shift register, the fill counter and the masked comparator, and outputs the combinational hit. pattern_seq_ctrl owns the FSM, the handshake, Y and the counter.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, with A_valid=1 toggling A -> Y=0, match_count=0, cfg_ready=1, busy=0, cfg_err=0.
2. Config len=2, pattern=2'b01, overlap=1. Stream A=0,1,1,0,1 with A_valid=1 each cycle -> Y pulses one cycle after the 2nd and 5th bits; match_count=2; busy=1.
3. Config len=3, pattern=3'b101. Stream 1,0,1,0,1:
   - overlap=1 -> 2 matches (after bits 3 and 5).
   - Re-run with overlap=0 -> 1 match (after bit 3); match_count cleared by the new config.
4. Offer cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses one cycle each; state stays IDLE; cfg_ready stays 1; previous match_count unchanged.
5. CNT_W=2, len=1, pattern=1'b1, stream five 1s with A_valid gaps between them -> Y pulses 5 times; match_count saturates at 3.
6. In RUN with len=2, pattern=01, after A=0:
   - Assert stop together with A_valid=1, A=1 -> no Y; IDLE next cycle; count retained.
   - Separately, drive rst=0 in the same cycle as a matching bit -> Y stays 0; all outputs return to reset values.
